// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared types for the streaming parity generator.
//   parity_mode_e : parity sense applied to words and frames (even / odd)
//   pstate_e      : frame tracking state (no frame open / frame open)
// -----------------------------------------------------------------------------
package parity_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  typedef enum logic {
    P_IDLE   = 1'b0,
    P_ACTIVE = 1'b1
  } pstate_e;

endpackage : parity_pkg

// File: rtl/parity_word_calc.sv
// -----------------------------------------------------------------------------
// parity_word_calc
// Combinational per-word parity.
//   i_data     in  WIDTH  data word
//   i_mode     in  1      PAR_EVEN / PAR_ODD
//   o_parity   out 1      parity bit to append to i_data
//   o_reduce   out 1      raw XOR reduction of i_data (feeds frame accumulator)
// -----------------------------------------------------------------------------
module parity_word_calc
  import parity_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  parity_mode_e     i_mode,
  output logic             o_parity,
  output logic             o_reduce
);

  logic w_reduce;

  assign w_reduce = ^i_data;
  assign o_reduce = w_reduce;
  // Odd mode inverts the bit so the total count of ones in {parity, data} is odd.
  assign o_parity = w_reduce ^ (i_mode == PAR_ODD);

endmodule : parity_word_calc

// File: rtl/parity_stream_gen.sv
// -----------------------------------------------------------------------------
// parity_stream_gen
// Streaming even/odd parity generator with running frame parity and a
// maximum frame length. One output register stage, full throughput.
//   clk           in  1       rising-edge clock
//   rst_n         in  1       asynchronous active-low reset
//   odd_mode      in  1       parity sense, sampled on the first word of a frame
//   in_valid      in  1       input word valid
//   in_ready      out 1       input word can be accepted
//   in_data       in  WIDTH   input word
//   in_last       in  1       final word of frame
//   out_valid     out 1       output beat valid
//   out_ready     in  1       downstream accepts beat
//   out_data      out WIDTH+1 {word_parity, data}
//   out_last      out 1       beat closes the frame (in_last or length limit)
//   frame_parity  out 1       frame parity, meaningful with out_last
//   word_count    out CW      1-based index of the beat within its frame
//   err_len       out 1       frame was force-closed at FRAME_MAX
// -----------------------------------------------------------------------------
module parity_stream_gen
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_MAX = 16,
  localparam int CW       = $clog2(FRAME_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic             out_last,
  output logic             frame_parity,
  output logic [CW-1:0]    word_count,
  output logic             err_len
);

  // Frame tracking state
  pstate_e      r_state;
  pstate_e      w_state_next;
  parity_mode_e r_mode_q;
  logic         r_acc;
  logic [CW-1:0] r_cnt;

  // Output register
  logic          r_out_valid;
  logic [WIDTH:0] r_out_data;
  logic          r_out_last;
  logic          r_frame_parity;
  logic [CW-1:0] r_word_count;
  logic          r_err_len;

  // Per-transfer combinational values
  logic          w_xfer;
  parity_mode_e  w_mode;
  logic          w_word_parity;
  logic          w_reduce;
  logic [CW-1:0] w_cnt_new;
  logic          w_close;
  logic          w_acc_new;
  logic          w_idle;

  // A held beat blocks input; a consumed beat frees the slot in the same cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;
  assign w_idle   = (r_state == P_IDLE);

  // The first word of a frame uses the live mode input since mode_q is only
  // being loaded on that same edge.
  assign w_mode = w_idle ? parity_mode_e'(odd_mode) : r_mode_q;

  parity_word_calc #(
    .WIDTH (WIDTH)
  ) u_word_calc (
    .i_data   (in_data),
    .i_mode   (w_mode),
    .o_parity (w_word_parity),
    .o_reduce (w_reduce)
  );

  assign w_cnt_new = w_idle ? CW'(1) : (r_cnt + 1'b1);
  assign w_close   = in_last || (w_cnt_new == CW'(FRAME_MAX));
  // In IDLE the accumulator is already zero, but gating it keeps the new
  // frame independent of any stale value.
  assign w_acc_new = (w_idle ? 1'b0 : r_acc) ^ w_reduce;

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    if (w_xfer) begin
      w_state_next = w_close ? P_IDLE : P_ACTIVE;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= P_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Frame context: latched mode, accumulator, word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= PAR_EVEN;
      r_acc    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_xfer) begin
      if (w_idle) begin
        r_mode_q <= parity_mode_e'(odd_mode);
      end
      r_acc <= w_close ? 1'b0 : w_acc_new;
      r_cnt <= w_close ? '0 : w_cnt_new;
    end
  end

  // Output register: loads on every transfer, drains when consumed with
  // nothing new arriving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_last     <= 1'b0;
      r_frame_parity <= 1'b0;
      r_word_count   <= '0;
      r_err_len      <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid    <= 1'b1;
      r_out_data     <= {w_word_parity, in_data};
      r_out_last     <= w_close;
      r_frame_parity <= w_acc_new ^ (w_mode == PAR_ODD);
      r_word_count   <= w_cnt_new;
      // Only a length-forced close is an error; in_last on the final
      // permitted word is a normal close.
      r_err_len      <= w_close && !in_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_last     = r_out_last;
  assign frame_parity = r_frame_parity;
  assign word_count   = r_word_count;
  assign err_len      = r_err_len;

endmodule : parity_stream_gen

// File: tb/tb_parity_stream_gen.sv
module tb_parity_stream_gen;

  localparam int WIDTH     = 8;
  localparam int FRAME_MAX = 4;
  localparam int CW        = $clog2(FRAME_MAX + 1);

  logic             clk;
  logic             rst_n;
  logic             odd_mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;
  logic             out_last;
  logic             frame_parity;
  logic [CW-1:0]    word_count;
  logic             err_len;

  int n_checks = 0;
  int n_errors = 0;

  parity_stream_gen #(
    .WIDTH     (WIDTH),
    .FRAME_MAX (FRAME_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .odd_mode     (odd_mode),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .frame_parity (frame_parity),
    .word_count   (word_count),
    .err_len      (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word and let one clock edge pass; outputs are sampled 1 ns later.
  task automatic send(input logic [7:0] d, input logic last, input logic mode);
    in_data  = d;
    in_last  = last;
    odd_mode = mode;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    $display("xfer data=%02h last=%0b mode=%0b -> out=%03h ol=%0b fp=%0b wc=%0d err=%0b",
             d, last, mode, out_data, out_last, frame_parity, word_count, err_len);
  endtask

  task automatic beat(input string tag, input logic [8:0] d, input logic last,
                      input logic fp, input logic [CW-1:0] wc, input logic err);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_last"},  32'(out_last),  32'(last));
    if (last) chk({tag, "_fp"}, 32'(frame_parity), 32'(fp));
    chk({tag, "_wc"},    32'(word_count), 32'(wc));
    chk({tag, "_err"},   32'(err_len),   32'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    odd_mode  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Even single-word frame
    send(8'hA5, 1'b1, 1'b0);
    beat("even1", 9'h0A5, 1'b1, 1'b0, 3'd1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Odd 3-word frame; mode change after word 1 must be ignored
    send(8'h01, 1'b0, 1'b1);
    beat("odd_w1", 9'h001, 1'b0, 1'b0, 3'd1, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    beat("odd_w2", 9'h103, 1'b0, 1'b0, 3'd2, 1'b0);
    send(8'h07, 1'b1, 1'b0);
    beat("odd_w3", 9'h007, 1'b1, 1'b1, 3'd3, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: 4 words, out_ready low for 3 cycles, in_last on word 4
    out_ready = 1'b0;
    send(8'h11, 1'b0, 1'b0);
    beat("bp_w0", 9'h011, 1'b0, 1'b0, 3'd1, 1'b0);
    in_data = 8'h12;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp_hold_data", 32'(out_data), 32'h011);
      chk("bp_hold_wc", 32'(word_count), 32'd1);
      chk("bp_hold_last", 32'(out_last), 32'd0);
      $display("hold cycle %0d out=%03h in_ready=%0b", i, out_data, in_ready);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    send(8'h12, 1'b0, 1'b0);
    beat("bp_w1", 9'h012, 1'b0, 1'b0, 3'd2, 1'b0);
    send(8'h13, 1'b0, 1'b0);
    beat("bp_w2", 9'h113, 1'b0, 1'b0, 3'd3, 1'b0);
    send(8'h80, 1'b1, 1'b0);
    beat("bp_w3", 9'h180, 1'b1, 1'b0, 3'd4, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Length limit: 4 words without in_last, then a new odd frame
    send(8'h01, 1'b0, 1'b0);
    beat("len_w1", 9'h101, 1'b0, 1'b0, 3'd1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    beat("len_w2", 9'h102, 1'b0, 1'b0, 3'd2, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    beat("len_w3", 9'h104, 1'b0, 1'b0, 3'd3, 1'b0);
    send(8'h08, 1'b0, 1'b0);
    beat("len_w4", 9'h108, 1'b1, 1'b0, 3'd4, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    beat("len_w5", 9'h100, 1'b0, 1'b0, 3'd1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    beat("len_w6", 9'h100, 1'b1, 1'b1, 3'd2, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset mid-frame
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_wc", 32'(word_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(8'h01, 1'b1, 1'b0);
    beat("post_rst", 9'h101, 1'b1, 1'b1, 3'd1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_parity_stream_gen
